// File: rtl/ac_pkg.sv
// Shared width helpers for the access-control stream packer.
// Each helper turns a top-level parameter set into a derived width or count,
// so every file sizes its counters and buses the same way.
package ac_pkg;

   // A counter that takes n distinct values needs at least one bit.
   function automatic int cnt_w(input int n);
      if (n <= 1) return 1;
      return $clog2(n);
   endfunction

   // Width of one input beat.
   function automatic int beat_w(input int pix_width, input int pix_per_beat);
      return pix_width * pix_per_beat;
   endfunction

   // Beats per destination row.
   function automatic int row_beats(input int img_width, input int pix_per_beat);
      return img_width / pix_per_beat;
   endfunction

   // A level counter must be able to hold the value depth itself.
   function automatic int lvl_w(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/ac_sfifo.sv
// Synchronous show-ahead FIFO. The head entry is always visible on dout_o,
// and level_o gives the number of stored entries. DEPTH is a power of two,
// so the read and write pointers wrap without extra logic.
module ac_sfifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16,
   localparam int AW = $clog2(DEPTH),
   localparam int LW = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push_i,
   input  logic [WIDTH-1:0] din_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] dout_o,
   output logic             full_o,
   output logic             empty_o,
   output logic [LW-1:0]    level_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_q;
   logic [AW-1:0]    rd_q;
   logic [LW-1:0]    level_q;
   logic [LW-1:0]    level_d;

   // Storage array. It has no reset; an entry is only read after it has been written.
   always_ff @(posedge clk) begin
      if (push_i) mem_q[wr_q] <= din_i;
   end

   // Next level. A push and a pop in the same cycle cancel out.
   always_comb begin
      level_d = level_q;
      if (push_i && !pop_i)      level_d = level_q + LW'(1);
      else if (!push_i && pop_i) level_d = level_q - LW'(1);
   end

   // Pointer and level registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_q    <= '0;
         rd_q    <= '0;
         level_q <= '0;
      end else begin
         if (push_i) wr_q <= wr_q + AW'(1);
         if (pop_i)  rd_q <= rd_q + AW'(1);
         level_q <= level_d;
      end
   end

   assign dout_o  = mem_q[rd_q];
   assign empty_o = (level_q == '0);
   assign full_o  = (level_q == LW'(DEPTH));
   assign level_o = level_q;

endmodule

// File: rtl/ac_stream_packer.sv
// Output buffer for access control. It packs pixel beats into N_PARALLEL-lane
// words for an AXI-Stream master. Each row ends its own word, padding any
// unused lanes. The first word of a frame carries user, and the last word of
// a row carries last. A flush closes any partial word and restarts the frame.
module ac_stream_packer
   import ac_pkg::*;
#(
   parameter int PIX_WIDTH      = 24,
   parameter int PIX_PER_BEAT   = 4,
   parameter int N_PARALLEL     = 2,
   parameter int DST_IMG_WIDTH  = 4096,
   parameter int DST_IMG_HEIGHT = 2160,
   parameter int FIFO_DEPTH     = 16,
   parameter int LANE_REVERSE   = 1,
   parameter logic [PIX_WIDTH*PIX_PER_BEAT-1:0] PAD_VALUE = '0
) (
   input  logic                                       clk,
   input  logic                                       rst,
   input  logic                                       s_valid,
   input  logic [PIX_WIDTH*PIX_PER_BEAT-1:0]          s_data,
   output logic                                       s_ready,
   input  logic                                       flush,
   output logic                                       m_valid,
   output logic [PIX_WIDTH*PIX_PER_BEAT*N_PARALLEL-1:0] m_data,
   output logic [N_PARALLEL-1:0]                      m_keep,
   output logic                                       m_last,
   output logic                                       m_user,
   input  logic                                       m_ready,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]            fifo_level,
   output logic                                       frame_done
);

   localparam int BEAT_W    = beat_w(PIX_WIDTH, PIX_PER_BEAT);
   localparam int OUT_W     = BEAT_W * N_PARALLEL;
   localparam int ROW_BEATS = row_beats(DST_IMG_WIDTH, PIX_PER_BEAT);
   localparam int LANE_W    = cnt_w(N_PARALLEL);
   localparam int COL_W     = cnt_w(ROW_BEATS);
   localparam int ROW_W     = cnt_w(DST_IMG_HEIGHT);
   localparam int ENT_W     = OUT_W + N_PARALLEL + 2;

   // Handshake: a beat transfers on s_valid & s_ready, a word on m_valid & m_ready.
   // While m_valid is high and m_ready is low, m_* hold the FIFO head unchanged.

   logic [LANE_W-1:0] lane_q, lane_d;
   logic [COL_W-1:0]  col_q, col_d;
   logic [ROW_W-1:0]  row_q, row_d;
   logic [N_PARALLEL-1:0][BEAT_W-1:0] pack_q, pack_d, beat_word, push_word;
   logic [N_PARALLEL-1:0] keep_q, keep_d, beat_keep, push_keep;
   logic first_q, first_d;
   logic flush_pend_q, flush_pend_d;
   logic frame_done_q, frame_done_d;
   logic push, pop, push_last, push_user;
   logic fifo_full, fifo_empty;
   logic flush_req, flush_go, accept;
   logic row_end, word_end, frame_end;
   logic [ENT_W-1:0] push_ent, head_ent;
   int   cur_pos;

   // A flush waits while the FIFO is full; input stays blocked until it completes.
   assign flush_req    = flush | flush_pend_q;
   assign flush_go     = flush_req & ~fifo_full;
   assign flush_pend_d = flush_req & ~flush_go;
   assign s_ready      = ~rst & ~fifo_full & ~flush & ~flush_pend_q;
   assign accept       = s_valid & s_ready;

   assign row_end   = (col_q == COL_W'(ROW_BEATS - 1));
   assign word_end  = row_end | (lane_q == LANE_W'(N_PARALLEL - 1));
   assign frame_end = row_end & (row_q == ROW_W'(DST_IMG_HEIGHT - 1));
   assign cur_pos   = (LANE_REVERSE != 0) ? (N_PARALLEL - 1 - int'(lane_q)) : int'(lane_q);

   // Pack and count. A completed word goes straight to the FIFO on the accepting edge.
   always_comb begin
      lane_d       = lane_q;
      col_d        = col_q;
      row_d        = row_q;
      pack_d       = pack_q;
      keep_d       = keep_q;
      first_d      = first_q;
      frame_done_d = 1'b0;
      push         = 1'b0;
      push_word    = pack_q;
      push_keep    = keep_q;
      push_last    = 1'b1;
      push_user    = first_q;
      beat_word    = pack_q;
      beat_keep    = keep_q;
      for (int i = 0; i < N_PARALLEL; i++) begin
         if (i == cur_pos) begin
            beat_word[i] = s_data;
            beat_keep[i] = 1'b1;
         end
      end
      if (flush_go) begin
         push    = (lane_q != '0);
         lane_d  = '0;
         col_d   = '0;
         row_d   = '0;
         pack_d  = {N_PARALLEL{PAD_VALUE}};
         keep_d  = '0;
         first_d = 1'b1;
      end else if (accept) begin
         if (word_end) begin
            push      = 1'b1;
            push_word = beat_word;
            push_keep = beat_keep;
            push_last = row_end;
            lane_d    = '0;
            pack_d    = {N_PARALLEL{PAD_VALUE}};
            keep_d    = '0;
            first_d   = 1'b0;
            if (row_end) begin
               col_d = '0;
               if (frame_end) begin
                  row_d        = '0;
                  first_d      = 1'b1;
                  frame_done_d = 1'b1;
               end else begin
                  row_d = row_q + ROW_W'(1);
               end
            end else begin
               col_d = col_q + COL_W'(1);
            end
         end else begin
            lane_d = lane_q + LANE_W'(1);
            col_d  = col_q + COL_W'(1);
            pack_d = beat_word;
            keep_d = beat_keep;
         end
      end
   end

   // Packer state registers. Reset discards any partial word and restarts the frame.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lane_q       <= '0;
         col_q        <= '0;
         row_q        <= '0;
         pack_q       <= {N_PARALLEL{PAD_VALUE}};
         keep_q       <= '0;
         first_q      <= 1'b1;
         flush_pend_q <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         lane_q       <= lane_d;
         col_q        <= col_d;
         row_q        <= row_d;
         pack_q       <= pack_d;
         keep_q       <= keep_d;
         first_q      <= first_d;
         flush_pend_q <= flush_pend_d;
         frame_done_q <= frame_done_d;
      end
   end

   assign push_ent = {push_user, push_last, push_keep, push_word};
   assign pop      = m_valid & m_ready;

   ac_sfifo #(
      .WIDTH (ENT_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (push),
      .din_i   (push_ent),
      .pop_i   (pop),
      .dout_o  (head_ent),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .level_o (fifo_level)
   );

   // The head entry is masked to zero while the FIFO is empty, so idle outputs are clean.
   assign m_valid    = ~fifo_empty;
   assign m_data     = m_valid ? head_ent[OUT_W-1:0] : '0;
   assign m_keep     = m_valid ? head_ent[OUT_W +: N_PARALLEL] : '0;
   assign m_last     = m_valid & head_ent[OUT_W+N_PARALLEL];
   assign m_user     = m_valid & head_ent[OUT_W+N_PARALLEL+1];
   assign frame_done = frame_done_q;

endmodule
